public_trace_compressor: RTL and testbench

// - Downstream observer for a stutter-capable target codeblock: consumes its public output and stutter flag.
// - Non-stutter cycles are sampled. Consecutive duplicate observations are collapsed, so only value changes are kept.
// - Changes are buffered and streamed out over a valid/ready interface.
// - Lets the hyperproperty harness compare observation sequences of source and target while ignoring stutter and repeats.

---
 rtl/obs_pkg.sv | 15 +
 rtl/obs_fifo.sv | 49 ++++
 rtl/public_trace_compressor.sv | 107 ++++++++++
 tb/tb_public_trace_compressor.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/obs_pkg.sv
// Shared types for the public trace compressor.
// Holds the default data width and the observer FSM encoding.
package obs_pkg;

    localparam int DATA_W_DEF = 2;

    localparam logic [1:0] DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        TRACK      = 2'd1,
        DONE       = DONE_ENC
    } state_e;

endpackage

// File: rtl/obs_fifo.sv
// Show-ahead synchronous FIFO with async active-low reset.
// Uses an extra pointer bit to tell full from empty.
module obs_fifo #(
    parameter int DATA_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Empty reads as zero so the output is clean out of reset.
    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/public_trace_compressor.sv
// Samples non-stutter target outputs, keeps only value changes,
// and streams them out through a small FIFO.
module public_trace_compressor
    import obs_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = 4,
    parameter int IDLE_LIMIT = 8,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stutter_in,
    input  logic [DATA_W-1:0] public_in,
    input  logic              obs_ready,
    output logic              obs_valid,
    output logic [DATA_W-1:0] obs_data,
    output logic              overflow,
    output logic              trace_done,
    output logic [CNT_W-1:0]  event_count
);

    localparam int IW = $clog2(IDLE_LIMIT + 1);
    localparam logic [IW-1:0] LIM = IW'(IDLE_LIMIT);

    state_e            state;
    state_e            state_n;
    logic [DATA_W-1:0] last_val;
    logic [DATA_W-1:0] last_n;
    logic [IW-1:0]     idle_cnt;
    logic [IW-1:0]     idle_n;
    logic [IW-1:0]     idle_inc;
    logic              want_push;
    logic              pop;
    logic              accept;
    logic              drop;
    logic              full;
    logic              empty;

    assign obs_valid  = !empty;
    assign pop        = obs_valid && obs_ready;
    assign accept     = want_push && (!full || pop);
    assign drop       = want_push && full && !pop;
    assign trace_done = (state == DONE);
    assign idle_inc   = (idle_cnt == LIM) ? idle_cnt : idle_cnt + 1'b1;

    always_comb begin
        state_n   = state;
        last_n    = last_val;
        idle_n    = idle_cnt;
        want_push = 1'b0;
        if (!stutter_in) begin
            unique case (state)
                WAIT_FIRST: begin
                    want_push = 1'b1;
                    last_n    = public_in;
                    state_n   = TRACK;
                end
                TRACK: begin
                    if (public_in != last_val) begin
                        want_push = 1'b1;
                        last_n    = public_in;
                        idle_n    = '0;
                    end else begin
                        idle_n = idle_inc;
                        if (idle_inc == LIM) state_n = DONE;
                    end
                end
                DONE: ;
                default: state_n = WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_FIRST;
            last_val    <= '0;
            idle_cnt    <= '0;
            overflow    <= 1'b0;
            event_count <= '0;
        end else begin
            state    <= state_n;
            last_val <= last_n;
            idle_cnt <= idle_n;
            if (drop) overflow <= 1'b1;
            if (accept && event_count != '1)
                event_count <= event_count + 1'b1;
        end
    end

    // Full-without-pop is filtered here; the FIFO would drop it anyway.
    obs_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .din   (public_in),
        .dout  (obs_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_public_trace_compressor.sv
// Scoreboard bench for public_trace_compressor: directed scenarios
// followed by randomized traffic against a queue-based reference model.
module tb_public_trace_compressor;

    localparam int DATA_W     = 2;
    localparam int DEPTH      = 4;
    localparam int IDLE_LIMIT = 8;
    localparam int CNT_W      = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              stutter_in;
    logic [DATA_W-1:0] public_in;
    logic              obs_ready;
    logic              obs_valid;
    logic [DATA_W-1:0] obs_data;
    logic              overflow;
    logic              trace_done;
    logic [CNT_W-1:0]  event_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                occ;
    bit                started;
    bit                done_m;
    bit                ovf_m;
    int                idle_m;
    int                cnt_m;
    logic [DATA_W-1:0] last_m;
    bit                cur_s;
    bit                cur_r;
    logic [DATA_W-1:0] cur_v;

    always #5 clk = ~clk;

    public_trace_compressor #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .IDLE_LIMIT (IDLE_LIMIT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stutter_in  (stutter_in),
        .public_in   (public_in),
        .obs_ready   (obs_ready),
        .obs_valid   (obs_valid),
        .obs_data    (obs_data),
        .overflow    (overflow),
        .trace_done  (trace_done),
        .event_count (event_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        occ     = 0;
        started = 0;
        done_m  = 0;
        ovf_m   = 0;
        idle_m  = 0;
        cnt_m   = 0;
        last_m  = '0;
    endtask

    // Reference behaviour for one rising edge, from the applied inputs.
    task automatic model_edge();
        bit want;
        bit popped;
        bit acc;
        want   = 0;
        popped = (occ > 0) && cur_r;
        if (!cur_s) begin
            if (!started) begin
                want    = 1;
                started = 1;
                last_m  = cur_v;
            end else if (!done_m) begin
                if (cur_v != last_m) begin
                    want   = 1;
                    last_m = cur_v;
                    idle_m = 0;
                end else begin
                    idle_m++;
                    if (idle_m >= IDLE_LIMIT) done_m = 1;
                end
            end
        end
        acc = want && (occ < DEPTH || popped);
        if (want && !acc) ovf_m = 1;
        if (acc) begin
            exp_q.push_back(cur_v);
            if (cnt_m < (1 << CNT_W) - 1) cnt_m++;
        end
        occ = occ - int'(popped) + int'(acc);
    endtask

    // Inputs change 2ns after the edge; the monitor samples at negedge.
    task automatic step(input bit s, input logic [DATA_W-1:0] v,
                        input bit r);
        cur_s      = s;
        cur_v      = v;
        cur_r      = r;
        stutter_in = s;
        public_in  = v;
        obs_ready  = r;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1;
        check("rst_obs_valid", 32'(obs_valid), 0);
        check("rst_obs_data", 32'(obs_data), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_trace_done", 32'(trace_done), 0);
        check("rst_event_count", 32'(event_count), 0);
        model_clear();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("obs_valid", 32'(obs_valid), 32'(occ > 0));
            check("overflow", 32'(overflow), 32'(ovf_m));
            check("trace_done", 32'(trace_done), 32'(done_m));
            check("event_count", 32'(event_count), 32'(cnt_m));
            if (obs_valid && obs_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL obs_extra: got %0d expected none",
                             obs_data);
                end else begin
                    check("obs_data", 32'(obs_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] rv;
        rst_n      = 1'b0;
        stutter_in = 1'b0;
        public_in  = '0;
        obs_ready  = 1'b0;
        cur_s      = 0;
        cur_r      = 0;
        cur_v      = '0;
        model_clear();
        @(posedge clk);
        #2;
        pulse_reset();

        // Duplicates collapse: 0,0,1,1,2 -> 0,1,2
        step(0, 0, 1); step(0, 0, 1); step(0, 1, 1);
        step(0, 1, 1); step(0, 2, 1); step(1, 2, 1);
        check("dedup_count", 32'(event_count), 3);
        pulse_reset();

        // Stuttered value never observed
        step(0, 1, 1); step(1, 3, 1); step(0, 1, 1); step(1, 0, 1);
        check("stutter_count", 32'(event_count), 1);
        check("stutter_empty", 32'(obs_valid), 0);
        pulse_reset();

        // Overflow with consumer stalled, then drain
        step(0, 0, 0); step(0, 1, 0); step(0, 2, 0);
        step(0, 3, 0); step(0, 0, 0); step(0, 1, 0);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(event_count), 4);
        check("ovf_head", 32'(obs_data), 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1);
        check("ovf_drained", 32'(obs_valid), 0);
        pulse_reset();

        // Full FIFO with simultaneous push and pop
        step(0, 0, 0); step(0, 1, 0); step(0, 2, 0); step(0, 3, 0);
        step(0, 0, 1); step(0, 1, 1); step(0, 2, 1);
        check("fullpp_overflow", 32'(overflow), 0);
        check("fullpp_count", 32'(event_count), 7);
        for (int i = 0; i < 5; i++) step(1, 0, 1);
        pulse_reset();

        // Idle limit: one observation, then trace_done blocks pushes
        for (int i = 0; i < 9; i++) step(0, 2, 1);
        check("idle_done", 32'(trace_done), 1);
        step(0, 3, 1); step(0, 3, 1);
        check("done_count", 32'(event_count), 1);
        check("done_empty", 32'(obs_valid), 0);
        pulse_reset();

        // Async reset with three entries buffered
        step(0, 1, 0); step(0, 2, 0); step(0, 3, 0);
        check("pre_rst_valid", 32'(obs_valid), 1);
        pulse_reset();
        step(0, 3, 1); step(0, 3, 1);
        check("post_rst_count", 32'(event_count), 1);

        // Randomized traffic
        rv = '0;
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) pulse_reset();
            if ($urandom_range(0, 2) == 0) rv = DATA_W'($urandom);
            step($urandom_range(0, 3) == 0, rv, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1, rv, 1);
        check("final_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
